cgra_config_loader: RTL and testbench

Loads a CGRA tile's bit-serial configuration chain from a word-wide host stream. It sits directly upstream of the PE blocks: it drives their `config_clk`, `config_reset` and `config_in` ports and receives `config_out` from the tail of the chain. It serializes incoming words MSB-first and generates the chain clock as a clk/2 strobe. It also captures the bits leaving the chain, so the previous configuration can be read back for verification.

---
 rtl/cgra_config_loader.sv | 100 ++++++++++
 tb/tb_cgra_config_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader.sv
// cgra_config_loader: serializes host words MSB-first into a CGRA config chain
// with a clk/2 chain clock, and captures the old chain contents for readback.
module cgra_config_loader #(
    parameter int size      = 32,
    parameter int CHAIN_LEN = 71
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [size-1:0] cfg_word,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    output logic            config_clk,
    output logic            config_reset,
    output logic            config_in,
    input  logic            config_out,
    output logic [size-1:0] rb_word,
    output logic            rb_valid,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(size + 1);
    localparam int RW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, DONE} state_t;

    state_t          state;
    logic [size-1:0] shreg, rb_sh;
    logic [CW-1:0]   bcnt;
    logic [RW-1:0]   rem;
    logic            ph, clr_c;
    logic            last_bit, word_end;

    assign last_bit     = rem == RW'(1);
    assign word_end     = last_bit || bcnt == CW'(size - 1);
    assign cfg_ready    = state == LOAD;
    assign config_reset = state == CLR;
    assign done         = state == DONE;
    assign busy         = state != IDLE;

    // config_in is set one cycle ahead so it is stable around each config_clk rise
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            rb_sh      <= '0;
            rb_word    <= '0;
            rb_valid   <= 1'b0;
            config_clk <= 1'b0;
            config_in  <= 1'b0;
            bcnt       <= '0;
            rem        <= '0;
            ph         <= 1'b0;
            clr_c      <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            rb_word  <= '0;
            case (state)
                IDLE: begin
                    clr_c <= 1'b0;
                    if (start) state <= CLR;
                end
                CLR: begin
                    clr_c <= 1'b1;
                    rem   <= RW'(CHAIN_LEN);
                    if (clr_c) state <= LOAD;
                end
                LOAD: if (cfg_valid) begin
                    shreg     <= cfg_word;
                    config_in <= cfg_word[size-1];
                    bcnt      <= '0;
                    ph        <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: if (!ph) begin
                    ph         <= 1'b1;
                    config_clk <= 1'b1;
                    rb_sh      <= {rb_sh[size-2:0], config_out};
                end else begin
                    ph         <= 1'b0;
                    config_clk <= 1'b0;
                    shreg      <= {shreg[size-2:0], 1'b0};
                    rem        <= rem - RW'(1);
                    bcnt       <= bcnt + CW'(1);
                    if (word_end) begin
                        // partial final word is left-aligned, low bits zero
                        rb_word  <= rb_sh << (CW'(size) - (bcnt + CW'(1)));
                        rb_valid <= 1'b1;
                        state    <= last_bit ? DONE : LOAD;
                        if (last_bit) config_in <= 1'b0;
                    end else begin
                        config_in <= shreg[size-2];
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cgra_config_loader.sv
// tb_cgra_config_loader: scoreboard bench with a 12-bit chain model (size=8)
// plus a second instance for the single-bit chain corner case.
module tb_cgra_config_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_word = 8'h00;
    logic       cfg_ready, config_clk, config_reset, config_in, config_out;
    logic [7:0] rb_word;
    logic       rb_valid, busy, done;

    logic        start2 = 1'b0, cfg_valid2 = 1'b0;
    logic [31:0] cfg_word2 = 32'h0;
    logic        cfg_ready2, config_clk2, config_reset2, config_in2;
    logic [31:0] rb_word2;
    logic        rb_valid2, busy2, done2;

    int tests = 0, fails = 0, cyc = 0;
    int t0, acc0, acc1, done_at, nclr, clr_first, npulse, stall_bad;
    logic [7:0]  rb_q[$];
    logic [11:0] chain = 12'h000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge config_clk) chain <= {chain[10:0], config_in};
    assign config_out = chain[11];

    cgra_config_loader #(.size(8), .CHAIN_LEN(12)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .config_clk(config_clk), .config_reset(config_reset),
        .config_in(config_in), .config_out(config_out), .rb_word(rb_word), .rb_valid(rb_valid),
        .busy(busy), .done(done));

    cgra_config_loader #(.size(32), .CHAIN_LEN(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cfg_word(cfg_word2), .cfg_valid(cfg_valid2),
        .cfg_ready(cfg_ready2), .config_clk(config_clk2), .config_reset(config_reset2),
        .config_in(config_in2), .config_out(1'b1), .rb_word(rb_word2), .rb_valid(rb_valid2),
        .busy(busy2), .done(done2));

    always @(negedge clk) if (rb_valid) begin
        tests++;
        if (rb_q.size() == 0) begin
            fails++;
            $display("FAIL rb_unexpected got %h", rb_word);
        end else begin
            if (rb_word !== rb_q[0]) begin
                fails++;
                $display("FAIL rb_word got %h exp %h", rb_word, rb_q[0]);
            end
            void'(rb_q.pop_front());
        end
    end

    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input int stall, input bit junk);
        int  n = 0, st = 0;
        bit  junked = 1'b0;
        rb_q.push_back(chain[11:4]);
        rb_q.push_back({chain[3:0], 4'h0});
        acc0 = -1; acc1 = -1; done_at = -1; nclr = 0; clr_first = -1; npulse = 0; stall_bad = 0;
        @(negedge clk);
        t0 = cyc; start = 1'b1; cfg_valid = 1'b1; cfg_word = w0;
        for (int i = 0; i < 300 && done_at < 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (config_reset) begin nclr++; if (clr_first < 0) clr_first = cyc - t0; end
            if (config_clk) npulse++;
            if (done) done_at = cyc - t0;
            if (junk && !junked && config_clk) begin start = 1'b1; junked = 1'b1; end
            if (cfg_ready && n == 1 && st < stall) begin
                cfg_valid = 1'b0;
                st++;
                if (config_clk || config_in !== w0[0]) stall_bad++;
            end else cfg_valid = 1'b1;
            cfg_word = n == 0 ? w0 : w1;
            if (cfg_ready && cfg_valid) begin
                if (n == 0) acc0 = cyc - t0; else acc1 = cyc - t0;
                n++;
            end
        end
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({cfg_ready, config_clk, config_reset, config_in, rb_valid, busy, done, rb_word} !== 15'h0) begin
            fails++; $display("FAIL reset_outputs got %h exp 0", {cfg_ready, config_clk, config_reset, config_in, rb_valid, busy, done, rb_word});
        end
        tests++;
        if ({cfg_ready2, config_clk2, config_reset2, config_in2, rb_valid2, busy2, done2, rb_word2} !== 39'h0) begin
            fails++; $display("FAIL reset_outputs2 got %h exp 0", {cfg_ready2, config_clk2, config_reset2, config_in2, rb_valid2, busy2, done2, rb_word2});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        do_load(8'hA5, 8'h3C, 0, 1'b0);
        tests++; if (clr_first != 1) begin fails++; $display("FAIL basic_clr_first got %0d exp 1", clr_first); end
        tests++; if (nclr != 2) begin fails++; $display("FAIL basic_clr_len got %0d exp 2", nclr); end
        tests++; if (acc0 != 3) begin fails++; $display("FAIL basic_acc0 got %0d exp 3", acc0); end
        tests++; if (acc1 != 20) begin fails++; $display("FAIL basic_acc1 got %0d exp 20", acc1); end
        tests++; if (done_at != 29) begin fails++; $display("FAIL basic_done got %0d exp 29", done_at); end
        tests++; if (npulse != 12) begin fails++; $display("FAIL basic_pulses got %0d exp 12", npulse); end
        tests++; if (chain !== 12'hA53) begin fails++; $display("FAIL basic_chain got %h exp a53", chain); end
    endtask

    task automatic test_readback;
        do_load(8'hFF, 8'hF0, 0, 1'b0);
        tests++; if (rb_q.size() != 0) begin fails++; $display("FAIL rb_missing got %0d left exp 0", rb_q.size()); end
        tests++; if (chain !== 12'hFFF) begin fails++; $display("FAIL rb_chain got %h exp fff", chain); end
        tests++; if (done_at != 29) begin fails++; $display("FAIL rb_done got %0d exp 29", done_at); end
    endtask

    task automatic test_stall;
        do_load(8'hA5, 8'h3C, 5, 1'b0);
        tests++; if (acc1 != 25) begin fails++; $display("FAIL stall_acc1 got %0d exp 25", acc1); end
        tests++; if (done_at != 34) begin fails++; $display("FAIL stall_done got %0d exp 34", done_at); end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL stall_hold got %0d bad cycles exp 0", stall_bad); end
        tests++; if (chain !== 12'hA53) begin fails++; $display("FAIL stall_chain got %h exp a53", chain); end
    endtask

    task automatic test_ignored;
        do_load(8'h5A, 8'hC3, 0, 1'b1);
        tests++; if (done_at != 29) begin fails++; $display("FAIL ign_done got %0d exp 29", done_at); end
        tests++; if (acc1 != 20) begin fails++; $display("FAIL ign_acc1 got %0d exp 20", acc1); end
        tests++; if (chain !== 12'h5AC) begin fails++; $display("FAIL ign_chain got %h exp 5ac", chain); end
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [11:0] pre = chain;
        int p = 0;
        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b1; cfg_word = 8'h00;
        for (int i = 0; i < 100 && p < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (config_clk) p++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({cfg_ready, config_clk, config_reset, config_in, rb_valid, busy, done, rb_word} !== 15'h0) begin
            fails++; $display("FAIL mid_reset_outputs got %h exp 0", {cfg_ready, config_clk, config_reset, config_in, rb_valid, busy, done, rb_word});
        end
        reset = 1'b0; cfg_valid = 1'b0;
        tests++; if (chain !== (pre << 5)) begin fails++; $display("FAIL mid_partial_chain got %h exp %h", chain, pre << 5); end
        do_load(8'hA5, 8'h3C, 0, 1'b0);
        tests++; if (nclr != 2) begin fails++; $display("FAIL mid_clr_len got %0d exp 2", nclr); end
        tests++; if (done_at != 29) begin fails++; $display("FAIL mid_done got %0d exp 29", done_at); end
        tests++; if (chain !== 12'hA53) begin fails++; $display("FAIL mid_chain got %h exp a53", chain); end
    endtask

    task automatic test_chain1;
        int p = 0, d = -1, nrb = 0;
        logic inbit = 1'b0;
        logic [31:0] rbw = 32'h0;
        @(negedge clk);
        t0 = cyc; start2 = 1'b1; cfg_valid2 = 1'b1; cfg_word2 = 32'h8000_0000;
        for (int i = 0; i < 40 && d < 0; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (config_clk2) begin p++; inbit = config_in2; end
            if (rb_valid2) begin nrb++; rbw = rb_word2; end
            if (done2) d = cyc - t0;
        end
        cfg_valid2 = 1'b0;
        tests++; if (p != 1) begin fails++; $display("FAIL c1_pulses got %0d exp 1", p); end
        tests++; if (inbit !== 1'b1) begin fails++; $display("FAIL c1_config_in got %b exp 1", inbit); end
        tests++; if (d != 6) begin fails++; $display("FAIL c1_done got %0d exp 6", d); end
        tests++; if (nrb != 1) begin fails++; $display("FAIL c1_rb_count got %0d exp 1", nrb); end
        tests++; if (rbw !== 32'h8000_0000) begin fails++; $display("FAIL c1_rb_word got %h exp 80000000", rbw); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_readback();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_chain1();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
